ll_window_ctrl: RTL and testbench

- Sequencer for the line-length datapath (abs-difference unit): gates its active-low enable per accepted sample and clears it at run start.
- Accumulates the per-sample |diff| over WINDOW_SIZE samples, reports the window sum and a threshold detect flag to the system controller.
- Sample data flows straight from source to datapath; this block handles only the handshake, sequencing and accumulation.

---
 rtl/ll_window_ctrl_if.sv | 33 +++
 rtl/ll_window_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ll_window_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ll_window_ctrl_if.sv
// Handshake, control and result bundle between the line-length window controller,
// its sample source / datapath and the system controller.
interface ll_window_ctrl_if #(
    parameter int OUTPUT_WIDTH = 64,
    parameter int WINDOW_SIZE  = 32
);
    localparam int ACC_W = OUTPUT_WIDTH + $clog2(WINDOW_SIZE);

    logic                    start;
    logic                    cont;
    logic                    stop;
    logic [ACC_W-1:0]        threshold;
    logic                    s_valid;
    logic                    s_ready;
    logic                    dp_en_n;
    logic                    dp_clr;
    logic [OUTPUT_WIDTH-1:0] diff_in;
    logic [ACC_W-1:0]        sum_out;
    logic                    sum_valid;
    logic                    detect;
    logic                    diff_err;
    logic                    busy;

    modport slave (
        input  start, cont, stop, threshold, s_valid, diff_in,
        output s_ready, dp_en_n, dp_clr, sum_out, sum_valid, detect, diff_err, busy
    );

    modport master (
        output start, cont, stop, threshold, s_valid, diff_in,
        input  s_ready, dp_en_n, dp_clr, sum_out, sum_valid, detect, diff_err, busy
    );
endinterface

// File: rtl/ll_window_ctrl.sv
// Line-length window controller: sequences the abs-difference datapath and sums WINDOW_SIZE diffs.
// Optional macro LL_HYST_EN: detect only after CONSEC_WIN consecutive over-threshold windows.
module ll_window_ctrl #(
    parameter int OUTPUT_WIDTH = 64,
    parameter int WINDOW_SIZE  = 32,
    parameter int CONSEC_WIN   = 3
) (
    input  logic           clk,
    input  logic           rst,
    ll_window_ctrl_if.slave bus
);
    localparam int ACC_W = OUTPUT_WIDTH + $clog2(WINDOW_SIZE);
    localparam int CNT_W = $clog2(WINDOW_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_PRIME  = 3'd2,
        S_ACCUM  = 3'd3,
        S_LAST   = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_sum_out;
    logic             r_pending;
    logic             r_stop_lat;
    logic             r_cont;
    logic             r_sum_valid;
    logic             r_detect;
    logic             r_diff_err;

    logic             w_s_ready;
    logic             w_accept;
    logic             w_diff_neg;
    logic             w_over;
    logic [ACC_W-1:0] w_diff_add;
    logic [ACC_W-1:0] w_acc_sum;

`ifdef LL_HYST_EN
    localparam int CONS_W = $clog2(CONSEC_WIN + 1);
    localparam logic [CONS_W-1:0] CONSEC_MAX = CONS_W'(CONSEC_WIN);
    logic [CONS_W-1:0] r_consec;
    logic [CONS_W-1:0] w_consec_nxt;
    assign w_consec_nxt = !w_over ? {CONS_W{1'b0}} :
                          (r_consec == CONSEC_MAX) ? r_consec : r_consec + CONS_W'(1);
`endif

    assign w_s_ready  = (r_state == S_PRIME) || (r_state == S_ACCUM);
    assign w_accept   = bus.s_valid & w_s_ready;
    // A negative diff means the datapath misbehaved; count it as zero and flag it.
    assign w_diff_neg = bus.diff_in[OUTPUT_WIDTH-1];
    assign w_diff_add = (r_pending && !w_diff_neg) ? ACC_W'(bus.diff_in) : {ACC_W{1'b0}};
    assign w_acc_sum  = r_acc + w_diff_add;
    assign w_over     = (r_sum_out >= bus.threshold);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = bus.start ? S_CLEAR : S_IDLE;
            S_CLEAR:  w_next_state = S_PRIME;
            S_PRIME:  w_next_state = w_accept ? S_ACCUM : S_PRIME;
            S_ACCUM:  w_next_state = (w_accept && (r_cnt == CNT_LAST)) ? S_LAST : S_ACCUM;
            S_LAST:   w_next_state = S_REPORT;
            S_REPORT: w_next_state = (r_stop_lat || !r_cont) ? S_IDLE : S_ACCUM;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Accumulation, run control latches and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= {CNT_W{1'b0}};
            r_acc       <= {ACC_W{1'b0}};
            r_sum_out   <= {ACC_W{1'b0}};
            r_pending   <= 1'b0;
            r_stop_lat  <= 1'b0;
            r_cont      <= 1'b0;
            r_sum_valid <= 1'b0;
            r_detect    <= 1'b0;
            r_diff_err  <= 1'b0;
`ifdef LL_HYST_EN
            r_consec    <= {CONS_W{1'b0}};
`endif
        end else begin
            r_sum_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cont     <= bus.cont;
                        r_stop_lat <= bus.stop;
                        r_detect   <= 1'b0;
                        r_diff_err <= 1'b0;
`ifdef LL_HYST_EN
                        r_consec   <= {CONS_W{1'b0}};
`endif
                    end
                end
                S_PRIME: begin
                    // The priming sample only loads the datapath delay register.
                    if (w_accept) begin
                        r_acc     <= {ACC_W{1'b0}};
                        r_cnt     <= {CNT_W{1'b0}};
                        r_pending <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    r_pending <= w_accept;
                    r_acc     <= w_acc_sum;
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LAST: begin
                    r_pending   <= 1'b0;
                    r_sum_out   <= w_acc_sum;
                    r_sum_valid <= 1'b1;
                end
                S_REPORT: begin
                    r_acc     <= {ACC_W{1'b0}};
                    r_cnt     <= {CNT_W{1'b0}};
                    r_pending <= 1'b0;
`ifdef LL_HYST_EN
                    r_consec  <= w_consec_nxt;
                    r_detect  <= (w_consec_nxt == CONSEC_MAX);
`else
                    r_detect  <= w_over;
`endif
                end
                default: begin
                    r_pending <= 1'b0;
                end
            endcase
            if (r_pending && w_diff_neg) begin
                r_diff_err <= 1'b1;
            end
            if ((r_state != S_IDLE) && bus.stop) begin
                r_stop_lat <= 1'b1;
            end
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.dp_en_n   = ~w_accept;
    assign bus.dp_clr    = (r_state == S_CLEAR);
    assign bus.sum_out   = r_sum_out;
    assign bus.sum_valid = r_sum_valid;
    assign bus.detect    = r_detect;
    assign bus.diff_err  = r_diff_err;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_ll_window_ctrl.sv
// Directed bench for ll_window_ctrl (WINDOW_SIZE=4) with a behavioural abs-difference datapath.
module tb_ll_window_ctrl;
    localparam int OW = 64;
    localparam int WS = 4;
    localparam int AW = OW + $clog2(WS);
`ifdef LL_HYST_EN
    localparam logic HYST = 1'b1;
`else
    localparam logic HYST = 1'b0;
`endif
    localparam logic DET_SINGLE = ~HYST;

    logic          clk;
    logic          rst;
    int            checks;
    int            errors;
    logic [OW-1:0] x_data;
    logic [OW-1:0] dp_prev;
    logic [OW-1:0] dp_diff;
    logic          neg_arm;

    ll_window_ctrl_if #(.OUTPUT_WIDTH(OW), .WINDOW_SIZE(WS)) bus ();

    ll_window_ctrl #(.OUTPUT_WIDTH(OW), .WINDOW_SIZE(WS), .CONSEC_WIN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.diff_in = dp_diff;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: registered |x - previous x| on each enabled cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_prev <= '0;
            dp_diff <= '0;
        end else if (bus.dp_clr) begin
            dp_prev <= '0;
            dp_diff <= '0;
        end else if (!bus.dp_en_n) begin
            dp_prev <= x_data;
            dp_diff <= neg_arm ? 64'hFFFF_FFFF_FFFF_FFF0 :
                       (x_data >= dp_prev) ? (x_data - dp_prev) : (dp_prev - x_data);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic c, input logic s);
        bus.start = 1'b1;
        bus.cont  = c;
        bus.stop  = s;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        #1;
        chk("clear_dp_clr", bus.dp_clr, 1);
        chk("clear_s_ready", bus.s_ready, 0);
        chk("clear_busy", bus.busy, 1);
        chk("start_detect_clr", bus.detect, 0);
        chk("start_err_clr", bus.diff_err, 0);
        @(negedge clk);
        #1;
        chk("prime_dp_clr", bus.dp_clr, 0);
        chk("prime_s_ready", bus.s_ready, 1);
    endtask

    task automatic send(input logic [OW-1:0] x, input int gaps);
        logic done;
        done = 1'b0;
        for (int g = 0; g < gaps; g++) begin
            bus.s_valid = 1'b0;
            #1;
            chk("gap_en_n", bus.dp_en_n, 1);
            @(negedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        x_data = x;
        #1;
        for (int t = 0; t < 20 && !done; t++) begin
            if (bus.s_ready) begin
                chk("accept_en_n", bus.dp_en_n, 0);
                @(posedge clk);
                done = 1'b1;
            end else begin
                chk("stall_en_n", bus.dp_en_n, 1);
                @(negedge clk);
                #1;
            end
        end
        chk("send_accepted", done, 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        #1;
    endtask

    task automatic expect_report(input logic [AW-1:0] sum, input logic busy_after);
        chk("last_s_ready", bus.s_ready, 0);
        chk("last_sum_valid", bus.sum_valid, 0);
        chk("last_busy", bus.busy, 1);
        @(negedge clk);
        #1;
        chk("report_sum_valid", bus.sum_valid, 1);
        chk("report_sum_out", bus.sum_out, sum);
        chk("report_s_ready", bus.s_ready, 0);
        @(negedge clk);
        #1;
        chk("post_sum_valid", bus.sum_valid, 0);
        chk("post_busy", bus.busy, busy_after);
        chk("post_sum_hold", bus.sum_out, sum);
    endtask

`ifdef LL_HYST_EN
    int unsigned hyst_x [24] = '{5, 10, 15, 20, 15, 10, 5, 0, 1, 2, 3, 5,
                                 10, 15, 20, 25, 20, 15, 10, 5, 10, 15, 20, 25};
    int unsigned hyst_sum [6] = '{20, 20, 5, 20, 20, 20};
    logic        hyst_det [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.cont    = 1'b0;
        bus.stop    = 1'b0;
        bus.s_valid = 1'b0;
        bus.threshold = AW'(13);
        x_data      = '0;
        neg_arm     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_dp_en_n", bus.dp_en_n, 1);
        chk("rst_dp_clr", bus.dp_clr, 0);
        chk("rst_sum_out", bus.sum_out, 0);
        chk("rst_sum_valid", bus.sum_valid, 0);
        chk("rst_detect", bus.detect, 0);
        chk("rst_diff_err", bus.diff_err, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Single window, threshold met exactly: diffs 3,4,0,6
        do_start(1'b0, 1'b0);
        send(10, 0); send(13, 0); send(9, 0); send(9, 0); send(15, 0);
        expect_report(AW'(13), 1'b0);
        chk("single_detect_eq", bus.detect, DET_SINGLE);

        // Same window, threshold just above
        bus.threshold = AW'(14);
        do_start(1'b0, 1'b0);
        send(10, 0); send(13, 0); send(9, 0); send(9, 0); send(15, 0);
        expect_report(AW'(13), 1'b0);
        chk("single_detect_below", bus.detect, 0);

        // Continuous: second window continues from last sample (diffs 10,0,0,0), stop ends it
        bus.threshold = AW'(13);
        do_start(1'b1, 1'b0);
        send(10, 0); send(13, 0); send(9, 0); send(9, 0); send(15, 0);
        expect_report(AW'(13), 1'b1);
        chk("cont_detect1", bus.detect, DET_SINGLE);
        chk("cont_no_reprime_ready", bus.s_ready, 1);
        chk("cont_no_reclear", bus.dp_clr, 0);
        send(5, 0);
        bus.stop = 1'b1;
        send(5, 0);
        bus.stop = 1'b0;
        send(5, 0); send(5, 0);
        expect_report(AW'(10), 1'b0);
        chk("cont_detect2", bus.detect, 0);

        // Backpressure: gaps in PRIME and ACCUM give the same sum
        do_start(1'b0, 1'b0);
        send(10, 2); send(13, 1); send(9, 3); send(9, 0); send(15, 2);
        expect_report(AW'(13), 1'b0);
        chk("bp_detect", bus.detect, DET_SINGLE);

        // Negative diff adds 0 and flags; start while busy is ignored
        bus.threshold = AW'(5);
        do_start(1'b0, 1'b0);
        send(10, 0); send(13, 0); send(9, 0);
        bus.start = 1'b1;
        send(9, 0);
        bus.start = 1'b0;
        chk("busy_start_no_clear", bus.dp_clr, 0);
        chk("busy_start_busy", bus.busy, 1);
        chk("busy_start_ready", bus.s_ready, 1);
        neg_arm = 1'b1;
        send(15, 0);
        neg_arm = 1'b0;
        expect_report(AW'(7), 1'b0);
        chk("neg_diff_err", bus.diff_err, 1);
        chk("neg_detect", bus.detect, DET_SINGLE);

        // Reset mid-ACCUM: outputs clear asynchronously, no report afterwards
        bus.threshold = AW'(13);
        do_start(1'b0, 1'b0);
        send(10, 0); send(13, 0); send(9, 0);
        bus.s_valid = 1'b1;
        x_data = 9;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_s_ready", bus.s_ready, 0);
        chk("midrst_dp_en_n", bus.dp_en_n, 1);
        chk("midrst_dp_clr", bus.dp_clr, 0);
        chk("midrst_sum_out", bus.sum_out, 0);
        chk("midrst_sum_valid", bus.sum_valid, 0);
        chk("midrst_detect", bus.detect, 0);
        chk("midrst_diff_err", bus.diff_err, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.s_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("postrst_sum_valid", bus.sum_valid, 0);
            chk("postrst_busy", bus.busy, 0);
        end

`ifdef LL_HYST_EN
        // Hysteresis: sums 20,20,5,20,20,20 vs 13 -> detect only on the last
        do_start(1'b1, 1'b0);
        send(0, 0);
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 4; i++) begin
                bus.stop = (w == 5) && (i == 0);
                send(OW'(hyst_x[w*4+i]), 0);
                bus.stop = 1'b0;
            end
            expect_report(AW'(hyst_sum[w]), (w != 5));
            chk("hyst_detect", bus.detect, hyst_det[w]);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
